// File: rtl/btn_event_gen.sv
// btn_event_gen: per-channel sync, debounce, press/release pulses and sticky events.
// Define BTN_AUTOREPEAT_EN to build the long-press HOLD state and auto-repeat.
module btn_event_gen #(
    parameter int NUM_BTN         = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int MIN_PULSE_WIDTH = 25000,
    parameter int HOLD_DELAY      = 20000000,
    parameter int REPEAT_PERIOD   = 4000000
) (
    input  logic               i_clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] i_btn,
    input  logic [NUM_BTN-1:0] i_evt_clr,
    output logic [NUM_BTN-1:0] o_btn,
    output logic [NUM_BTN-1:0] o_press,
    output logic [NUM_BTN-1:0] o_release,
    output logic [NUM_BTN-1:0] o_repeat,
    output logic [NUM_BTN-1:0] o_hold,
    output logic [NUM_BTN-1:0] o_evt
);

    localparam logic INV = (ACTIVE_LOW != 0);
    localparam int DW = $clog2(MIN_PULSE_WIDTH);
    localparam logic [DW-1:0] DB_LAST = DW'(MIN_PULSE_WIDTH - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int HMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
    localparam int HW = $clog2(HMAX);
    localparam logic [HW-1:0] HD_LAST = HW'(HOLD_DELAY - 1);
    localparam logic [HW-1:0] RP_LAST = HW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HOLD
    } state_t;
`else
    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;
`endif

    if (NUM_BTN < 1 || NUM_BTN > 16 || MIN_PULSE_WIDTH < 2 ||
        HOLD_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("btn_event_gen: parameter out of range");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          s;
        logic          lvl;
        logic          rise;
        logic          fall;
        logic          press;
        logic          rel;
        logic          rpt;
        logic          evt;
        logic [DW-1:0] db_cnt;
        state_t        state;

        // Synchronisers reset to the raw released level so s starts at 0
        assign s    = sync2 ^ INV;
        assign rise = s & ~lvl & (db_cnt == DB_LAST);
        assign fall = ~s & lvl & (db_cnt == DB_LAST);

        always_ff @(posedge i_clk) begin
            if (!reset_n) begin
                sync1  <= INV;
                sync2  <= INV;
                lvl    <= 1'b0;
                db_cnt <= '0;
            end else begin
                sync1 <= i_btn[i];
                sync2 <= sync1;
                if (s == lvl) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    lvl    <= s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic          hold;
        logic [HW-1:0] h_cnt;

        // Release takes priority over a terminal count on the same edge
        always_ff @(posedge i_clk) begin
            if (!reset_n) begin
                state <= IDLE;
                h_cnt <= '0;
                press <= 1'b0;
                rel   <= 1'b0;
                rpt   <= 1'b0;
                hold  <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                rpt   <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= PRESSED;
                            press <= 1'b1;
                            h_cnt <= '0;
                        end
                    end
                    PRESSED: begin
                        if (fall) begin
                            state <= IDLE;
                            rel   <= 1'b1;
                            h_cnt <= '0;
                        end else if (h_cnt == HD_LAST) begin
                            state <= HOLD;
                            rpt   <= 1'b1;
                            hold  <= 1'b1;
                            h_cnt <= '0;
                        end else begin
                            h_cnt <= h_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (fall) begin
                            state <= IDLE;
                            rel   <= 1'b1;
                            hold  <= 1'b0;
                            h_cnt <= '0;
                        end else if (h_cnt == RP_LAST) begin
                            rpt   <= 1'b1;
                            h_cnt <= '0;
                        end else begin
                            h_cnt <= h_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        hold  <= 1'b0;
                        h_cnt <= '0;
                    end
                endcase
            end
        end

        assign o_repeat[i] = rpt;
        assign o_hold[i]   = hold;
`else
        always_ff @(posedge i_clk) begin
            if (!reset_n) begin
                state <= IDLE;
                press <= 1'b0;
                rel   <= 1'b0;
            end else begin
                press <= 1'b0;
                rel   <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= PRESSED;
                            press <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (fall) begin
                            state <= IDLE;
                            rel   <= 1'b1;
                        end
                    end
                endcase
            end
        end

        assign rpt         = 1'b0;
        assign o_repeat[i] = 1'b0;
        assign o_hold[i]   = 1'b0;
`endif

        // Set beats clear when both land on the same edge
        always_ff @(posedge i_clk) begin
            if (!reset_n) begin
                evt <= 1'b0;
            end else begin
                evt <= press | rpt | (evt & ~i_evt_clr[i]);
            end
        end

        assign o_btn[i]     = lvl;
        assign o_press[i]   = press;
        assign o_release[i] = rel;
        assign o_evt[i]     = evt;
    end

endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: scoreboard bench for btn_event_gen against a window/time model.
// Follows BTN_AUTOREPEAT_EN to pick the expected repeat/hold behaviour.
module tb_btn_event_gen;

    localparam int N   = 2;
    localparam int MPW = 4;
    localparam int HD  = 10;
    localparam int RP  = 5;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] btn = '1;
    logic [N-1:0] clr = '0;
    logic [N-1:0] o_btn, o_press, o_release, o_repeat, o_hold, o_evt;

    btn_event_gen #(
        .NUM_BTN        (N),
        .ACTIVE_LOW     (1),
        .MIN_PULSE_WIDTH(MPW),
        .HOLD_DELAY     (HD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .i_clk    (clk),
        .reset_n  (rstn),
        .i_btn    (btn),
        .i_evt_clr(clr),
        .o_btn    (o_btn),
        .o_press  (o_press),
        .o_release(o_release),
        .o_repeat (o_repeat),
        .o_hold   (o_hold),
        .o_evt    (o_evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic [N-1:0] rep;
        logic [N-1:0] hld;
        logic [N-1:0] evt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Model: accepted level flips once the last MPW synchronised samples all
    // disagree with it; repeats/hold follow from time elapsed since the press.
    bit             m_s1[N];
    bit             m_s2[N];
    bit             m_lvl[N];
    bit             m_prs[N];
    bit             m_rep[N];
    bit             m_evt[N];
    logic [MPW-1:0] m_hist[N];
    int             m_nv[N];
    int             m_tp[N];
    int             cyc = 0;

    function automatic exp_t model_edge(bit r, logic [N-1:0] b, logic [N-1:0] k);
        exp_t e;
        bit   s, acc, rel, rep, hld;
        int   d;
        e = '0;
        for (int c = 0; c < N; c++) begin
            if (!r) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_lvl[c] = 1'b0;
                m_prs[c] = 1'b0; m_rep[c] = 1'b0; m_evt[c] = 1'b0;
                m_hist[c] = '0; m_nv[c] = 0;
            end else begin
                s = m_s2[c];
                m_hist[c] = {m_hist[c][MPW-2:0], s};
                if (m_nv[c] < MPW) m_nv[c]++;
                acc = (m_nv[c] == MPW) && (m_hist[c] == {MPW{~m_lvl[c]}});
                m_evt[c] = m_prs[c] | m_rep[c] | (m_evt[c] & ~k[c]);
                if (acc) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_nv[c] = 0;
                    if (m_lvl[c]) m_tp[c] = cyc;
                end
                rel = acc && !m_lvl[c];
                d = cyc - m_tp[c];
                rep = AR && m_lvl[c] && !acc && d >= HD && ((d - HD) % RP) == 0;
                hld = AR && m_lvl[c] && d >= HD;
                m_prs[c] = acc && m_lvl[c];
                m_rep[c] = rep;
                m_s2[c] = m_s1[c];
                m_s1[c] = ~b[c];
                e.lvl[c] = m_lvl[c];
                e.prs[c] = m_prs[c];
                e.rel[c] = rel;
                e.rep[c] = rep;
                e.hld[c] = hld;
                e.evt[c] = m_evt[c];
            end
        end
        cyc++;
        return e;
    endfunction

    task automatic step(bit r, logic [N-1:0] b, logic [N-1:0] k);
        @(negedge clk);
        rstn = r;
        btn  = b;
        clr  = k;
        sb.push_back(model_edge(r, b, k));
    endtask

    task automatic idle(int n, logic [N-1:0] b);
        for (int j = 0; j < n; j++) step(1'b1, b, '0);
    endtask

    task automatic chk(string nm, logic [N-1:0] a, logic [N-1:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, a, x);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("o_btn", o_btn, e.lvl);
            chk("o_press", o_press, e.prs);
            chk("o_release", o_release, e.rel);
            chk("o_repeat", o_repeat, e.rep);
            chk("o_hold", o_hold, e.hld);
            chk("o_evt", o_evt, e.evt);
        end
    end

    initial begin
        int           len;
        logic [N-1:0] cur;
        logic [N-1:0] k;
        bit           r;
        // Reset with both buttons held, then re-acceptance after release of reset
        for (int j = 0; j < 3; j++) step(1'b0, 2'b00, '0);
        idle(10, 2'b00);
        idle(10, 2'b11);
        // Glitch shorter than the debounce window
        idle(3, 2'b10);
        idle(10, 2'b11);
        // Clean press on ch0 with clears around the event-set edge
        for (int j = 0; j < 6; j++) step(1'b1, 2'b10, '0);
        step(1'b1, 2'b10, 2'b01);
        step(1'b1, 2'b10, 2'b01);
        idle(4, 2'b10);
        idle(10, 2'b11);
        // Long press on ch1 to exercise hold and auto-repeat
        idle(40, 2'b01);
        idle(12, 2'b11);
        step(1'b1, 2'b11, 2'b11);
        idle(3, 2'b11);
        // Randomised segments with sparse resets and clears
        for (int seg = 0; seg < 150; seg++) begin
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(30, 60)
                                              : $urandom_range(1, 12);
            cur = N'($urandom_range(0, 3));
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 299) != 0);
                k = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 3)) : '0;
                step(r, cur, k);
            end
        end
        idle(20, 2'b11);
        for (int j = 0; j < 10 && sb.size() > 0; j++) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
